iicmb_wb_sequencer: RTL and testbench
=====================================

IICMB_WB_SEQUENCER -- requirements
Module: iicmb_wb_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, max clk_i cycles waiting for irq_i per command.
REQ-002 SHALL have parameter BUS_W, default 4, width of the bus-select field.
REQ-003 clk_i  in  1  single clock; all logic on rising edge.
REQ-004 rst_i  in  1  reset, asynchronous, active-low.
REQ-005 req_valid_i  in  1  transaction request.
REQ-006 req_ready_o  out  1  request accepted when high with req_valid_i.
REQ-007 req_rnw_i  in  1  1=read, 0=write.
REQ-008 req_bus_i  in  BUS_W  IICMB bus number.
REQ-009 req_addr_i  in  7  I2C slave address.
REQ-010 req_len_i  in  8  data byte count; 0 = address-only probe.
REQ-011 wr_data_i  in  8  write byte.
REQ-012 wr_data_valid_i  in  1  write byte available.
REQ-013 wr_data_ready_o  out  1  one-cycle pulse: wr_data_i captured.
REQ-014 rd_data_o  out  8  read byte.
REQ-015 rd_data_valid_o  out  1  one-cycle pulse; no backpressure.
REQ-016 done_o  out  1  one-cycle pulse at transaction end.
REQ-017 status_o  out  2  valid with done_o: 00 ok, 01 NAK, 10 arbitration lost, 11 timeout/error.
REQ-018 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls.
REQ-019 wb_adr_o  out  2  register: 0 CSR, 1 DPR, 2 CMDR, 3 FSMR.
REQ-020 wb_dat_o  out  8; wb_dat_i  in  8; wb_ack_i  in  1; irq_i  in  1 (IICMB interrupt).

Function
REQ-021 Wishbone access: cyc/stb/we/adr/dat driven together, held until wb_ack_i sampled high, all deasserted the next cycle; at least one idle cycle between accesses; one access in flight max.
REQ-022 After reset, first action SHALL be CSR write 0xC0 (enable + IE), once; req_ready_o stays low until that access is acked.
REQ-023 States: INIT, IDLE, SETBUS, START, ADDR, WDATA, RDATA, STOP, WAIT_IRQ, CLR, DONE.
REQ-024 IDLE: req_ready_o=1; accept on req_valid_i, latch rnw/bus/addr/len, go SETBUS.
REQ-025 Command issue = DPR write (if operand) then CMDR write; codes: set_bus 0x06, start 0x04, write 0x01, read-ack 0x02, read-nak 0x03, stop 0x05.
REQ-026 After each CMDR write: WAIT_IRQ until irq_i high, then CLR reads CMDR; bit7 DON continue, bit6 NAK, bit5 AL, bit4 ERR.
REQ-027 SETBUS: DPR<=req_bus; START: no operand; ADDR: DPR<={addr,rnw}.
REQ-028 WDATA: per byte wait wr_data_valid_i, pulse wr_data_ready_o, DPR<=byte, CMDR<=0x01; repeat len times.
REQ-029 RDATA: bytes 1..len-1 use 0x02, last byte 0x03; after DON, read DPR, pulse rd_data_valid_o with byte.
REQ-030 len=0: ADDR then STOP.
REQ-031 NAK on ADDR or WDATA: skip remaining bytes, issue STOP, status 01.
REQ-032 AL: no STOP, go DONE, status 10; ERR: issue STOP, status 11.
REQ-033 Timeout: 16-bit counter reloaded per WAIT_IRQ; expiry -> DONE, status 11, no STOP; INIT re-run before next IDLE.
REQ-034 STOP completion with DON -> DONE: done_o pulse, status 00 unless already set, then IDLE.
REQ-035 Byte counter 8-bit, decrementing, no wrap (stops at 0).

Reset
REQ-036 rst_i low, any state: immediately state INIT, all outputs 0 (wb_*, req_ready_o, pulses, status_o, rd_data_o), counters 0; mid-transfer abort leaves no Wishbone access pending.

Verification
REQ-037 Reset release, no request -> single CSR write 0xC0, then req_ready_o=1.
REQ-038 Write bus 5, addr 0x22, len 1, data 0x78, ack each irq with CMDR=0x80 -> WB sequence DPR<=05, CMDR<=06, rd CMDR, CMDR<=04, rd, DPR<=44, CMDR<=01, rd, DPR<=78, CMDR<=01, rd, CMDR<=05, rd; done_o, status 00.
REQ-039 Read addr 0x50, len 3, slave returns 0x11,0x22,0x33 -> CMDR codes 02,02,03; rd_data_valid_o three pulses with those bytes; status 00.
REQ-040 Address NAK (CMDR=0x40 after ADDR) -> no data commands, CMDR<=05 issued, status 01.
REQ-041 irq_i held low, TIMEOUT_CYCLES=100 -> done_o 100 cycles after WAIT_IRQ entry, status 11; reset asserted mid-WDATA -> wb_cyc_o low same cycle.

Source files
------------

// File: rtl/iicmb_wb_sequencer.sv
// iicmb_wb_sequencer
//   Turns byte-level I2C transaction requests into the Wishbone register
//   traffic that drives an IICMB I2C master core. Each request selects a bus,
//   sends START and the address byte, moves req_len_i data bytes in either
//   direction, sends STOP and then reports a two-bit status.
//
// Ports
//   clk_i, rst_i                  clock; asynchronous active-low reset
//   req_valid_i / req_ready_o     request handshake
//   req_rnw_i, req_bus_i,         transaction description, latched at accept
//   req_addr_i, req_len_i         (len 0 = address-only probe)
//   wr_data_i / wr_data_valid_i   write byte stream; wr_data_ready_o pulses
//                                 once per byte taken
//   rd_data_o / rd_data_valid_o   read byte stream (one-cycle pulse)
//   done_o, status_o              end-of-transaction pulse and status
//                                 (00 ok, 01 NAK, 10 arbitration lost,
//                                 11 error/timeout)
//   wb_*                          Wishbone master towards the IICMB core
//   irq_i                         IICMB command-complete interrupt
module iicmb_wb_sequencer #(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int BUS_W          = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_rnw_i,
    input  logic [BUS_W-1:0] req_bus_i,
    input  logic [6:0]       req_addr_i,
    input  logic [7:0]       req_len_i,
    input  logic [7:0]       wr_data_i,
    input  logic             wr_data_valid_i,
    output logic             wr_data_ready_o,
    output logic [7:0]       rd_data_o,
    output logic             rd_data_valid_o,
    output logic             done_o,
    output logic [1:0]       status_o,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [1:0]       wb_adr_o,
    output logic [7:0]       wb_dat_o,
    input  logic [7:0]       wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             irq_i
);

    localparam logic [1:0]  A_CSR  = 2'd0;
    localparam logic [1:0]  A_DPR  = 2'd1;
    localparam logic [1:0]  A_CMDR = 2'd2;

    localparam logic [7:0]  C_SET_BUS  = 8'h06;
    localparam logic [7:0]  C_START    = 8'h04;
    localparam logic [7:0]  C_WRITE    = 8'h01;
    localparam logic [7:0]  C_READ_ACK = 8'h02;
    localparam logic [7:0]  C_READ_NAK = 8'h03;
    localparam logic [7:0]  C_STOP     = 8'h05;
    localparam logic [7:0]  CSR_ENABLE = 8'hC0;   // core enable + interrupt enable

    localparam logic [1:0]  ST_OK  = 2'b00;
    localparam logic [1:0]  ST_NAK = 2'b01;
    localparam logic [1:0]  ST_AL  = 2'b10;
    localparam logic [1:0]  ST_ERR = 2'b11;

    localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_SETBUS, S_START, S_ADDR, S_WDATA,
        S_RDATA, S_STOP, S_WAIT_IRQ, S_CLR, S_DONE
    } state_t;

    state_t             state_q, cmd_q;   // cmd_q: command state awaiting its completion
    logic               phase_q;          // 0: operand (or command) access, 1: second access
    logic               rnw_q, tmo_q;
    logic [BUS_W-1:0]   bus_q;
    logic [6:0]         addr_q;
    logic [7:0]         cnt_q;
    logic [15:0]        tmr_q;
    logic [1:0]         status_q;
    logic               ready_q, wr_ready_q, rd_valid_q, done_q;
    logic [7:0]         rd_data_q;
    logic               cyc_q, stb_q, we_q;
    logic [1:0]         adr_q;
    logic [7:0]         dat_q;

    // Access the current state wants to launch once the bus is free.
    logic               acc_go, acc_we;
    logic [1:0]         acc_adr;
    logic [7:0]         acc_dat;

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        acc_go  = 1'b0;
        acc_we  = 1'b1;
        acc_adr = A_CMDR;
        acc_dat = 8'h00;
        case (state_q)
            S_INIT: begin
                acc_go  = 1'b1;
                acc_adr = A_CSR;
                acc_dat = CSR_ENABLE;
            end
            S_SETBUS: begin
                acc_go = 1'b1;
                if (!phase_q) begin
                    acc_adr = A_DPR;
                    acc_dat = 8'(bus_q);
                end else begin
                    acc_dat = C_SET_BUS;
                end
            end
            S_START: begin
                acc_go  = 1'b1;
                acc_dat = C_START;
            end
            S_ADDR: begin
                acc_go = 1'b1;
                if (!phase_q) begin
                    acc_adr = A_DPR;
                    acc_dat = {addr_q, rnw_q};
                end else begin
                    acc_dat = C_WRITE;
                end
            end
            S_WDATA: begin
                if (!phase_q) begin
                    acc_go  = wr_data_valid_i;
                    acc_adr = A_DPR;
                    acc_dat = wr_data_i;
                end else begin
                    acc_go  = 1'b1;
                    acc_dat = C_WRITE;
                end
            end
            S_RDATA: begin
                acc_go = 1'b1;
                if (!phase_q) begin
                    // Last byte is NAKed so the slave releases the bus.
                    acc_dat = (cnt_q == 8'd1) ? C_READ_NAK : C_READ_ACK;
                end else begin
                    acc_we  = 1'b0;
                    acc_adr = A_DPR;
                end
            end
            S_STOP: begin
                acc_go  = 1'b1;
                acc_dat = C_STOP;
            end
            S_CLR: begin
                acc_go = 1'b1;
                acc_we = 1'b0;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order. The
    // asynchronous reset drops the Wishbone strobes immediately, so an
    // aborted transfer never leaves an access pending.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_INIT;
            cmd_q      <= S_INIT;
            phase_q    <= 1'b0;
            rnw_q      <= 1'b0;
            tmo_q      <= 1'b0;
            bus_q      <= '0;
            addr_q     <= '0;
            cnt_q      <= '0;
            tmr_q      <= '0;
            status_q   <= ST_OK;
            ready_q    <= 1'b0;
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            rd_data_q  <= '0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            we_q       <= 1'b0;
            adr_q      <= '0;
            dat_q      <= '0;
        end else begin
            wr_ready_q <= 1'b0;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
            if (cyc_q) begin
                if (wb_ack_i) begin
                    cyc_q <= 1'b0;
                    stb_q <= 1'b0;
                    we_q  <= 1'b0;
                    adr_q <= '0;
                    dat_q <= '0;
                    case (state_q)
                        S_INIT: begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                        end
                        S_CLR: begin
                            // Priority: AL, then STOP completion, ERR, NAK, DON.
                            if (wb_dat_i[5]) begin
                                status_q <= ST_AL;
                                state_q  <= S_DONE;
                                done_q   <= 1'b1;
                            end else if (cmd_q == S_STOP) begin
                                if (!wb_dat_i[7] && status_q == ST_OK) status_q <= ST_ERR;
                                state_q <= S_DONE;
                                done_q  <= 1'b1;
                            end else if (wb_dat_i[4] || (!wb_dat_i[6] && !wb_dat_i[7])) begin
                                status_q <= ST_ERR;
                                state_q  <= S_STOP;
                            end else if (wb_dat_i[6]) begin
                                status_q <= ST_NAK;
                                state_q  <= S_STOP;
                            end else begin
                                case (cmd_q)
                                    S_SETBUS: state_q <= S_START;
                                    S_START:  state_q <= S_ADDR;
                                    S_ADDR: begin
                                        if (cnt_q == 8'd0) state_q <= S_STOP;
                                        else if (rnw_q)    state_q <= S_RDATA;
                                        else               state_q <= S_WDATA;
                                    end
                                    S_WDATA: begin
                                        state_q <= (cnt_q > 8'd1) ? S_WDATA : S_STOP;
                                        cnt_q   <= (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
                                    end
                                    default: begin  // S_RDATA: fetch the byte from DPR
                                        state_q <= S_RDATA;
                                        phase_q <= 1'b1;
                                    end
                                endcase
                            end
                        end
                        default: begin
                            if (we_q && adr_q == A_CMDR) begin
                                cmd_q   <= state_q;
                                state_q <= S_WAIT_IRQ;
                                tmr_q   <= TMO_LOAD;
                                phase_q <= 1'b0;
                            end else if (we_q) begin
                                phase_q <= 1'b1;
                            end else begin
                                rd_data_q  <= wb_dat_i;
                                rd_valid_q <= 1'b1;
                                phase_q    <= 1'b0;
                                if (cnt_q <= 8'd1) state_q <= S_STOP;
                                cnt_q <= (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
                            end
                        end
                    endcase
                end
            end else begin
                if (acc_go) begin
                    cyc_q <= 1'b1;
                    stb_q <= 1'b1;
                    we_q  <= acc_we;
                    adr_q <= acc_adr;
                    dat_q <= acc_dat;
                    if (state_q == S_WDATA && !phase_q) wr_ready_q <= 1'b1;
                end
                case (state_q)
                    S_IDLE: begin
                        if (req_valid_i && ready_q) begin
                            ready_q  <= 1'b0;
                            rnw_q    <= req_rnw_i;
                            bus_q    <= req_bus_i;
                            addr_q   <= req_addr_i;
                            cnt_q    <= req_len_i;
                            status_q <= ST_OK;
                            phase_q  <= 1'b0;
                            state_q  <= S_SETBUS;
                        end
                    end
                    S_WAIT_IRQ: begin
                        if (irq_i) begin
                            state_q <= S_CLR;
                        end else if (tmr_q == 16'd0) begin
                            // Core state unknown: skip STOP and re-initialise it.
                            status_q <= ST_ERR;
                            tmo_q    <= 1'b1;
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                        end else begin
                            tmr_q <= tmr_q - 16'd1;
                        end
                    end
                    S_DONE: begin
                        state_q <= tmo_q ? S_INIT : S_IDLE;
                        ready_q <= !tmo_q;
                        tmo_q   <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_ready_o     = ready_q;
    assign wr_data_ready_o = wr_ready_q;
    assign rd_data_o       = rd_data_q;
    assign rd_data_valid_o = rd_valid_q;
    assign done_o          = done_q;
    assign status_o        = status_q;
    assign wb_cyc_o        = cyc_q;
    assign wb_stb_o        = stb_q;
    assign wb_we_o         = we_q;
    assign wb_adr_o        = adr_q;
    assign wb_dat_o        = dat_q;

endmodule

// File: tb/tb_iicmb_wb_sequencer.sv
// Scoreboard bench for iicmb_wb_sequencer: a Wishbone/IICMB slave model
// answers accesses, while a monitor compares every access, read byte and
// done status against queues filled by the directed stimulus.
module tb_iicmb_wb_sequencer;

    localparam int BUS_W = 4;
    localparam int TMO   = 100;

    logic             clk_i = 1'b0;
    logic             rst_i = 1'b0;
    logic             req_valid_i = 1'b0;
    logic             req_ready_o;
    logic             req_rnw_i = 1'b0;
    logic [BUS_W-1:0] req_bus_i = '0;
    logic [6:0]       req_addr_i = '0;
    logic [7:0]       req_len_i = '0;
    logic [7:0]       wr_data_i = '0;
    logic             wr_data_valid_i = 1'b0;
    logic             wr_data_ready_o;
    logic [7:0]       rd_data_o;
    logic             rd_data_valid_o;
    logic             done_o;
    logic [1:0]       status_o;
    logic             wb_cyc_o, wb_stb_o, wb_we_o;
    logic [1:0]       wb_adr_o;
    logic [7:0]       wb_dat_o;
    logic [7:0]       wb_dat_i = '0;
    logic             wb_ack_i = 1'b0;
    logic             irq_i = 1'b0;

    iicmb_wb_sequencer #(.TIMEOUT_CYCLES(TMO), .BUS_W(BUS_W)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_rnw_i(req_rnw_i), .req_bus_i(req_bus_i),
        .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .wr_data_i(wr_data_i), .wr_data_valid_i(wr_data_valid_i),
        .wr_data_ready_o(wr_data_ready_o),
        .rd_data_o(rd_data_o), .rd_data_valid_o(rd_data_valid_o),
        .done_o(done_o), .status_o(status_o),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i),
        .wb_ack_i(wb_ack_i), .irq_i(irq_i)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;
    int cyc_cnt = 0;
    int last_cmdr_wr_cyc = 0;
    int done_cyc = 0;
    bit irq_en = 1'b1;
    bit irq_pend = 1'b0;
    int irq_dly = 0;

    logic [10:0] exp_wb[$];     // {we, adr, dat}; dat is 0 for reads
    logic [7:0]  exp_rd[$];
    logic [1:0]  exp_st[$];
    logic [7:0]  cmdr_resp[$];  // CMDR read values; 0x80 (DON) when empty
    logic [7:0]  dpr_resp[$];

    always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: got nothing, expected an event", name);
    endtask

    task automatic e_wr(input logic [1:0] a, input logic [7:0] d);
        exp_wb.push_back({1'b1, a, d});
    endtask

    task automatic e_rd(input logic [1:0] a);
        exp_wb.push_back({1'b0, a, 8'h00});
    endtask

    // CMDR command write followed by the status read of CMDR.
    task automatic e_cmd(input logic [7:0] code);
        e_wr(2'd2, code);
        e_rd(2'd2);
    endtask

    // Slave model and monitor.
    initial begin
        logic [10:0] got;
        forever begin
            @(negedge clk_i);
            if (!rst_i) begin
                wb_ack_i = 1'b0;
                irq_i    = 1'b0;
                irq_pend = 1'b0;
            end else begin
                if (irq_pend) begin
                    if (irq_dly == 0) irq_i = 1'b1;
                    else irq_dly--;
                end
                if (wb_cyc_o && wb_stb_o && !wb_ack_i) begin
                    got = {wb_we_o, wb_adr_o, wb_we_o ? wb_dat_o : 8'h00};
                    if (exp_wb.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL wb_access: got unexpected %03h, expected no access", got);
                    end else begin
                        check("wb_access", 32'(got), 32'(exp_wb.pop_front()));
                    end
                    wb_ack_i = 1'b1;
                    if (!wb_we_o && wb_adr_o == 2'd2) begin
                        wb_dat_i = (cmdr_resp.size() != 0) ? cmdr_resp.pop_front() : 8'h80;
                        irq_i    = 1'b0;
                        irq_pend = 1'b0;
                    end else if (!wb_we_o && wb_adr_o == 2'd1) begin
                        wb_dat_i = (dpr_resp.size() != 0) ? dpr_resp.pop_front() : 8'h00;
                    end else if (wb_we_o && wb_adr_o == 2'd2) begin
                        last_cmdr_wr_cyc = cyc_cnt;
                        if (irq_en) begin
                            irq_pend = 1'b1;
                            irq_dly  = 2;
                        end
                    end
                end else begin
                    wb_ack_i = 1'b0;
                end
                if (rd_data_valid_o) begin
                    if (exp_rd.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL rd_data: got unexpected %02h, expected no byte", rd_data_o);
                    end else begin
                        check("rd_data", 32'(rd_data_o), 32'(exp_rd.pop_front()));
                    end
                end
                if (done_o) begin
                    if (exp_st.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL status: got unexpected done status %0d, expected no done", status_o);
                    end else begin
                        check("status", 32'(status_o), 32'(exp_st.pop_front()));
                    end
                end
            end
        end
    end

    task automatic wait_ready();
        bit ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (req_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("req_ready_timeout");
    endtask

    task automatic issue(input logic rnw, input logic [BUS_W-1:0] bus,
                         input logic [6:0] addr, input logic [7:0] len);
        wait_ready();
        req_valid_i = 1'b1;
        req_rnw_i   = rnw;
        req_bus_i   = bus;
        req_addr_i  = addr;
        req_len_i   = len;
        @(negedge clk_i);
        req_valid_i = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok = 1'b0;
        wr_data_i       = b;
        wr_data_valid_i = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk_i);
            if (wr_data_ready_o) begin
                ok = 1'b1;
                break;
            end
        end
        wr_data_valid_i = 1'b0;
        if (!ok) fail_now("wr_data_ready_timeout");
    endtask

    task automatic wait_done();
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                ok = 1'b1;
                done_cyc = cyc_cnt;
                break;
            end
        end
        if (!ok) fail_now("done_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, expected end of test");
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk_i);
        check("reset_outputs",
              32'({wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, req_ready_o,
                   wr_data_ready_o, rd_data_o, rd_data_valid_o, done_o, status_o}), 32'd0);
        e_wr(2'd0, 8'hC0);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("ready_during_init", 32'(req_ready_o), 32'd0);
        wait_ready();

        // Write: bus 5, addr 0x22, one byte 0x78.
        e_wr(2'd1, 8'h05); e_cmd(8'h06); e_cmd(8'h04);
        e_wr(2'd1, 8'h44); e_cmd(8'h01);
        e_wr(2'd1, 8'h78); e_cmd(8'h01); e_cmd(8'h05);
        exp_st.push_back(2'b00);
        issue(1'b0, 4'd5, 7'h22, 8'd1);
        send_byte(8'h78);
        wait_done();

        // Read: bus 2, addr 0x50, three bytes.
        e_wr(2'd1, 8'h02); e_cmd(8'h06); e_cmd(8'h04);
        e_wr(2'd1, 8'hA1); e_cmd(8'h01);
        e_cmd(8'h02); e_rd(2'd1);
        e_cmd(8'h02); e_rd(2'd1);
        e_cmd(8'h03); e_rd(2'd1);
        e_cmd(8'h05);
        dpr_resp.push_back(8'h11); dpr_resp.push_back(8'h22); dpr_resp.push_back(8'h33);
        exp_rd.push_back(8'h11);   exp_rd.push_back(8'h22);   exp_rd.push_back(8'h33);
        exp_st.push_back(2'b00);
        issue(1'b1, 4'd2, 7'h50, 8'd3);
        wait_done();

        // Address NAK: no data commands, STOP, status 01.
        cmdr_resp.push_back(8'h80); cmdr_resp.push_back(8'h80);
        cmdr_resp.push_back(8'h40); cmdr_resp.push_back(8'h80);
        e_wr(2'd1, 8'h01); e_cmd(8'h06); e_cmd(8'h04);
        e_wr(2'd1, 8'h78); e_cmd(8'h01); e_cmd(8'h05);
        exp_st.push_back(2'b01);
        issue(1'b0, 4'd1, 7'h3C, 8'd2);
        wait_done();

        // Address-only probe (len 0).
        e_wr(2'd1, 8'h00); e_cmd(8'h06); e_cmd(8'h04);
        e_wr(2'd1, 8'h20); e_cmd(8'h01); e_cmd(8'h05);
        exp_st.push_back(2'b00);
        issue(1'b0, 4'd0, 7'h10, 8'd0);
        wait_done();

        // Arbitration lost on START: no STOP, status 10.
        cmdr_resp.push_back(8'h80); cmdr_resp.push_back(8'h20);
        e_wr(2'd1, 8'h07); e_cmd(8'h06); e_cmd(8'h04);
        exp_st.push_back(2'b10);
        issue(1'b1, 4'd7, 7'h33, 8'd1);
        wait_done();

        // Timeout: irq never comes; done TMO cycles after WAIT_IRQ entry, then re-init.
        irq_en = 1'b0;
        e_wr(2'd1, 8'h03); e_wr(2'd2, 8'h06);
        exp_st.push_back(2'b11);
        e_wr(2'd0, 8'hC0);
        issue(1'b0, 4'd3, 7'h11, 8'd1);
        wait_done();
        check("timeout_cycles", 32'(done_cyc - last_cmdr_wr_cyc - 1), 32'(TMO));
        wait_ready();
        irq_en = 1'b1;

        // Reset while the second write byte's DPR access is on the bus.
        e_wr(2'd1, 8'h04); e_cmd(8'h06); e_cmd(8'h04);
        e_wr(2'd1, 8'h44); e_cmd(8'h01);
        e_wr(2'd1, 8'hA5); e_cmd(8'h01);
        e_wr(2'd1, 8'h5A);
        issue(1'b0, 4'd4, 7'h22, 8'd2);
        send_byte(8'hA5);
        send_byte(8'h5A);
        #1 rst_i = 1'b0;
        #1;
        check("abort_cyc_stb", 32'({wb_cyc_o, wb_stb_o}), 32'd0);
        check("abort_ready_done", 32'({req_ready_o, done_o, status_o}), 32'd0);
        repeat (3) @(negedge clk_i);
        e_wr(2'd0, 8'hC0);
        rst_i = 1'b1;
        wait_ready();

        repeat (5) @(negedge clk_i);
        check("wb_queue_drained", 32'(exp_wb.size()), 32'd0);
        check("rd_queue_drained", 32'(exp_rd.size()), 32'd0);
        check("status_queue_drained", 32'(exp_st.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
